// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory loader. Parses a byte stream
//               (16-bit word count, then big-endian 32-bit words), writes
//               each word to consecutive word addresses from 0, and holds the
//               core in reset until the image is fully written.
//               Optional trailing XOR checksum byte when the macro
//               IMEM_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_global,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Largest legal word count: the full memory, 2^ADDR_W words.
    localparam logic [16:0] c_CAPACITY = 17'd1 << ADDR_W;

    state_t              r_state_q,     w_state_d;
    logic [15:0]         r_len_q,       w_len_d;
    logic [1:0]          r_byte_idx_q,  w_byte_idx_d;
    logic [15:0]         r_word_cnt_q,  w_word_cnt_d;
    logic [23:0]         r_asm_q,       w_asm_d;
    logic [ADDR_W-1:0]   r_addr_q,      w_addr_d;
    logic [31:0]         r_wdata_q,     w_wdata_d;
    logic                r_we_q,        w_we_d;
    logic                r_cpu_reset_q, w_cpu_reset_d;
    logic                r_done_q,      w_done_d;
    logic                r_err_q,       w_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum_q,      w_csum_d;
`endif
    logic                w_xfer;
    logic [15:0]         w_len_rx;

    // Ready is decoded from state and gated by the reset input so no byte is
    // consumed while the block is being held in reset.
    always_comb begin
        byte_ready = 1'b0;
        if (reset_global) begin
            case (r_state_q)
                ST_LEN_HI, ST_LEN_LO, ST_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM:                       byte_ready = 1'b1;
`endif
                default:                       byte_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer   = byte_valid && byte_ready;
    assign w_len_rx = {r_len_q[15:8], byte_data};

    // Next-state and next-output logic; outputs are registered from the
    // upcoming state so they line up with the state they describe.
    always_comb begin
        w_state_d    = r_state_q;
        w_len_d      = r_len_q;
        w_byte_idx_d = r_byte_idx_q;
        w_word_cnt_d = r_word_cnt_q;
        w_asm_d      = r_asm_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_we_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_csum_d     = r_csum_q;
`endif
        case (r_state_q)
            ST_LEN_HI: begin
                if (w_xfer) begin
                    w_len_d[15:8] = byte_data;
                    w_state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_len_d[7:0] = byte_data;
                    if (w_len_rx == 16'd0 || {1'b0, w_len_rx} > c_CAPACITY) begin
                        w_state_d = ST_ERR;
                    end else begin
                        w_state_d    = ST_DATA;
                        w_byte_idx_d = 2'd0;
                        w_word_cnt_d = 16'd0;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_asm_d = {r_asm_q[15:0], byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_d = r_csum_q ^ byte_data;
`endif
                    if (r_byte_idx_q == 2'd3) begin
                        // Last byte completes the word; present it during WRITE.
                        w_byte_idx_d = 2'd0;
                        w_state_d    = ST_WRITE;
                        w_we_d       = 1'b1;
                        w_wdata_d    = {r_asm_q, byte_data};
                    end else begin
                        w_byte_idx_d = r_byte_idx_q + 2'd1;
                    end
                end
            end
            ST_WRITE: begin
                // Address advances only after the write, so a full-memory
                // image wraps to 0 without ever writing there twice.
                w_addr_d     = r_addr_q + ADDR_W'(1);
                w_word_cnt_d = r_word_cnt_q + 16'd1;
                if (w_word_cnt_d == r_len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_d = ST_CSUM;
`else
                    w_state_d = ST_DONE;
`endif
                end else begin
                    w_state_d = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    w_state_d = (byte_data == r_csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                w_state_d = r_state_q;
            end
            default: begin
                w_state_d = ST_ERR;
            end
        endcase

        w_cpu_reset_d = (w_state_d != ST_DONE);
        w_done_d      = (w_state_d == ST_DONE);
        w_err_d       = (w_state_d == ST_ERR);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_global) begin
            r_state_q     <= ST_LEN_HI;
            r_len_q       <= 16'd0;
            r_byte_idx_q  <= 2'd0;
            r_word_cnt_q  <= 16'd0;
            r_asm_q       <= 24'd0;
            r_addr_q      <= '0;
            r_wdata_q     <= 32'd0;
            r_we_q        <= 1'b0;
            r_cpu_reset_q <= 1'b1;
            r_done_q      <= 1'b0;
            r_err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum_q      <= 8'd0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_len_q       <= w_len_d;
            r_byte_idx_q  <= w_byte_idx_d;
            r_word_cnt_q  <= w_word_cnt_d;
            r_asm_q       <= w_asm_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_we_q        <= w_we_d;
            r_cpu_reset_q <= w_cpu_reset_d;
            r_done_q      <= w_done_d;
            r_err_q       <= w_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum_q      <= w_csum_d;
`endif
        end
    end

    assign imem_we    = r_we_q;
    assign imem_addr  = r_addr_q;
    assign imem_wdata = r_wdata_q;
    assign cpu_reset  = r_cpu_reset_q;
    assign load_done  = r_done_q;
    assign load_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Builds byte images from
//               lists of words, drives them with optional random gaps, and
//               compares captured memory writes and status flags against the
//               word list and the loader's stated cycle timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset_global = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset_global (reset_global),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Captured memory writes.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    logic [31:0] exp_words[$];   // image contents (the reference model)
    logic [7:0]  stream[$];      // bytes to send
    int          xfer_cyc[$];    // cycle of each accepted byte

    // Serialise exp_words: count MSB first, words MSB first, optional XOR byte.
    task automatic build_image(input bit bad_csum);
        logic [7:0] x;
        int n;
        n = exp_words.size();
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        x = 8'h00;
        foreach (exp_words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                stream.push_back(8'(exp_words[i] >> (8 * b)));
                x = x ^ 8'(exp_words[i] >> (8 * b));
            end
        end
        if (bad_csum) x = x ^ 8'h01;
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    // Offer stream[0..nbytes-1]; returns at the negedge where the last byte is
    // about to be taken on the next rising edge.
    task automatic send_bytes(input bit random_valid, input int nbytes);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        xfer_cyc.delete();
        while (idx < nbytes && budget < 20000) begin
            @(negedge clock);
            budget++;
            byte_valid = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = byte_valid ? stream[idx] : 8'($urandom);
            if (byte_valid && byte_ready) begin
                xfer_cyc.push_back(cyc);
                idx++;
            end
        end
        if (idx < nbytes) begin
            errors++; checks++;
            $display("FAIL stream_timeout sent=%0d need=%0d", idx, nbytes);
        end
    endtask

    task automatic apply_reset;
        @(negedge clock);
        reset_global = 1'b0;
        byte_valid   = 1'b0;
        @(negedge clock);
        reset_global = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset_global = 1'b0;
        byte_valid   = 1'b1;
        byte_data    = 8'hA5;
        @(negedge clock);
        checks++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err}
            !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b we=%b addr=%h wd=%h cr=%b dn=%b er=%b exp 0 0 00 0 1 0 0",
                     byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err);
        end
        reset_global = 1'b1;
        byte_valid   = 1'b0;
        #1;
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", byte_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_basic;
        apply_reset();
        exp_words = '{32'h20080005, 32'h2009000A};
        build_image(1'b0);
        send_bytes(1'b0, stream.size());
        checks++;
        if (xfer_cyc.size() >= 7 && (xfer_cyc[6] - xfer_cyc[2] !== 5 || xfer_cyc[6] - xfer_cyc[5] !== 2)) begin
            errors++;
            $display("FAIL basic_word_rate got=%0d/%0d exp=5/2",
                     xfer_cyc[6] - xfer_cyc[2], xfer_cyc[6] - xfer_cyc[5]);
        end
        @(negedge clock);
        byte_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL basic_csum_done got dn=%b cr=%b exp 1 0", load_done, cpu_reset);
        end
`else
        checks++;
        if ({imem_we, imem_addr, imem_wdata, load_done, cpu_reset, byte_ready}
            !== {1'b1, 8'h01, 32'h2009000A, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_last_write got we=%b addr=%h wd=%h dn=%b cr=%b rdy=%b exp 1 01 2009000a 0 1 0",
                     imem_we, imem_addr, imem_wdata, load_done, cpu_reset, byte_ready);
        end
        @(negedge clock);
        checks++;
        if ({load_done, cpu_reset, load_err, imem_we, byte_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL basic_done got dn=%b cr=%b er=%b we=%b rdy=%b exp 1 0 0 0 0",
                     load_done, cpu_reset, load_err, imem_we, byte_ready);
        end
`endif
        checks++;
        if (wr_addr_q.size() !== exp_words.size()) begin
            errors++;
            $display("FAIL basic_wr_count got=%0d exp=%0d", wr_addr_q.size(), exp_words.size());
        end
        for (int i = 0; i < exp_words.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL basic_wr%0d got addr=%h data=%h exp addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], ADDR_W'(i), exp_words[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            if (r == 0) begin
                exp_words = '{32'h20080005, 32'h2009000A};
            end else begin
                exp_words.delete();
                for (int k = 0; k < int'($urandom_range(1, 8)); k++) exp_words.push_back($urandom);
            end
            build_image(1'b0);
            send_bytes(1'b1, stream.size());
            @(negedge clock);
            byte_valid = 1'b0;
            repeat (2) @(negedge clock);
            checks++;
            if (load_done !== 1'b1 || cpu_reset !== 1'b0 || load_err !== 1'b0) begin
                errors++;
                $display("FAIL bp%0d_done got dn=%b cr=%b er=%b exp 1 0 0", r, load_done, cpu_reset, load_err);
            end
            checks++;
            if (wr_addr_q.size() !== exp_words.size()) begin
                errors++;
                $display("FAIL bp%0d_wr_count got=%0d exp=%0d", r, wr_addr_q.size(), exp_words.size());
            end
            for (int i = 0; i < exp_words.size() && i < wr_addr_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL bp%0d_wr%0d got addr=%h data=%h exp addr=%h data=%h",
                             r, i, wr_addr_q[i], wr_data_q[i], ADDR_W'(i), exp_words[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len;
        apply_reset();
        stream = '{8'h00, 8'h00};
        send_bytes(1'b0, 2);
        @(negedge clock);
        checks++;
        if ({load_err, byte_ready, cpu_reset, load_done, imem_we} !== 5'b10100) begin
            errors++;
            $display("FAIL zero_len_err got er=%b rdy=%b cr=%b dn=%b we=%b exp 1 0 1 0 0",
                     load_err, byte_ready, cpu_reset, load_done, imem_we);
        end
        byte_data = 8'h55;
        repeat (3) @(negedge clock);
        byte_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() !== 0 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_nowrite got writes=%0d er=%b exp 0 1", wr_addr_q.size(), load_err);
        end
    endtask

    task automatic test_oversize;
        apply_reset();
        stream = '{8'h01, 8'h01};
        send_bytes(1'b0, 2);
        @(negedge clock);
        byte_valid = 1'b0;
        checks++;
        if ({load_err, cpu_reset, load_done} !== 3'b110) begin
            errors++;
            $display("FAIL oversize_err got er=%b cr=%b dn=%b exp 1 1 0", load_err, cpu_reset, load_done);
        end
        // Exactly full memory: 256 words must land at 0..255 and wrap to 0.
        apply_reset();
        exp_words.delete();
        for (int k = 0; k < 256; k++) exp_words.push_back($urandom);
        build_image(1'b0);
        send_bytes(1'b0, stream.size());
        @(negedge clock);
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({load_done, load_err, cpu_reset} !== 3'b100 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL full_done got dn=%b er=%b cr=%b addr=%h exp 1 0 0 00",
                     load_done, load_err, cpu_reset, imem_addr);
        end
        checks++;
        if (wr_addr_q.size() !== 256) begin
            errors++;
            $display("FAIL full_wr_count got=%0d exp=256", wr_addr_q.size());
        end
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL full_wr%0d got addr=%h data=%h exp addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], ADDR_W'(i), exp_words[i]);
            end
        end
    endtask

    task automatic test_reset_midload;
        exp_words = '{32'h20080005, 32'h2009000A};
        build_image(1'b0);
        for (int p = 0; p < 2; p++) begin
            apply_reset();
            // Abort after 5 bytes, then after 7 bytes once the first write is out.
            send_bytes(1'b0, (p == 0) ? 5 : 7);
            @(negedge clock);
            byte_valid = 1'b0;
            if (p == 1) repeat (3) @(negedge clock);
            reset_global = 1'b0;
            @(negedge clock);
            checks++;
            if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err}
                !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL midload%0d_reset got rdy=%b we=%b addr=%h wd=%h cr=%b dn=%b er=%b exp 0 0 00 0 1 0 0",
                         p, byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err);
            end
            reset_global = 1'b1;
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_bytes(1'b0, stream.size());
        @(negedge clock);
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (load_done !== 1'b1 || wr_addr_q.size() !== 2) begin
            errors++;
            $display("FAIL midload_reload got dn=%b writes=%0d exp 1 2", load_done, wr_addr_q.size());
        end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL midload_wr%0d got addr=%h data=%h exp addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], ADDR_W'(i), exp_words[i]);
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The XOR of the eight basic-image data bytes is 0x0E.
    task automatic test_checksum;
        for (int bad = 0; bad < 2; bad++) begin
            apply_reset();
            exp_words = '{32'h20080005, 32'h2009000A};
            build_image(bad[0]);
            checks++;
            if (stream[stream.size() - 1] !== (bad ? 8'h0F : 8'h0E)) begin
                errors++;
                $display("FAIL csum%0d_byte got=%h exp=%h", bad, stream[stream.size() - 1], bad ? 8'h0F : 8'h0E);
            end
            send_bytes(1'b0, stream.size());
            @(negedge clock);
            byte_valid = 1'b0;
            checks++;
            if ({load_done, load_err, cpu_reset} !== (bad ? 3'b011 : 3'b100)) begin
                errors++;
                $display("FAIL csum%0d_status got dn=%b er=%b cr=%b exp %b",
                         bad, load_done, load_err, cpu_reset, bad ? 3'b011 : 3'b100);
            end
            checks++;
            if (wr_addr_q.size() !== 2) begin
                errors++;
                $display("FAIL csum%0d_wr_count got=%0d exp=2", bad, wr_addr_q.size());
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_oversize();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
